// File: rtl/fpu_round_pack.sv
// fpu_round_pack: rounds an unpacked FPU result (nearest-even) and packs it to IEEE-754 layout.
// Latency: 2 cycles from accepted input to out_valid; throughput 1 beat/cycle.
// Backpressure: out_ready low stalls both stages; in_ready is combinational from out_ready (no skid).
module fpu_round_pack #(
  parameter int EXPONENT_WIDTH    = 11,
  parameter int SIGNIFICAND_WIDTH = 52,
  parameter int EXTRA_BITS        = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          in_sign,
  input  logic [EXPONENT_WIDTH+1:0]                     in_exponent,
  input  logic [SIGNIFICAND_WIDTH+EXTRA_BITS:0]         in_significand,
  input  logic                                          in_is_nan,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [EXPONENT_WIDTH+SIGNIFICAND_WIDTH:0]     out_packed,
  output logic                                          out_overflow,
  output logic                                          out_underflow,
  output logic                                          out_inexact
);

  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = SIGNIFICAND_WIDTH;
  localparam int XW = EXTRA_BITS;

  // Stage 1 (rounded) state
  logic              s1_vld_q;
  logic              s1_sign_q;
  logic [EW+1:0]     s1_exp_q;
  logic [MW+1:0]     s1_sum_q;
  logic              s1_inexact_q;
  logic              s1_nonzero_q;
  logic              s1_nan_q;

  // Stage 2 (packed) state, drives the outputs directly
  logic              s2_vld_q;
  logic [EW+MW:0]    s2_packed_q;
  logic              s2_ovf_q;
  logic              s2_unf_q;
  logic              s2_inx_q;

  // Handshake: a stage moves when it is empty or its consumer moves
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv;

  // Round-to-nearest-even on the incoming significand
  logic          rnd_l;
  logic          rnd_r;
  logic          rnd_s;
  logic          rnd_up;
  logic [MW+1:0] rnd_sum;

  always_comb begin
    rnd_l   = in_significand[XW];
    rnd_r   = in_significand[XW-1];
    rnd_s   = |in_significand[XW-2:0];
    rnd_up  = rnd_r && (rnd_s || rnd_l);
    rnd_sum = {1'b0, in_significand[MW+XW:XW]} + {{(MW+1){1'b0}}, rnd_up};
  end

  // Stage 1 register: capture rounded sum and beat metadata
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_sum_q     <= '0;
      s1_inexact_q <= 1'b0;
      s1_nonzero_q <= 1'b0;
      s1_nan_q     <= 1'b0;
    end else if (s1_adv) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_sign_q    <= in_sign;
        s1_exp_q     <= in_exponent;
        s1_sum_q     <= rnd_sum;
        s1_inexact_q <= rnd_r || rnd_s;
        s1_nonzero_q <= |in_significand;
        s1_nan_q     <= in_is_nan;
      end
    end
  end

  // Renormalise on carry-out; the exponent is widened by one bit so +1 cannot wrap
  logic          nrm_carry;
  logic [MW:0]   nrm_sig;
  logic [EW+2:0] nrm_exp;
  logic          nrm_ovf;
  logic          nrm_unf;

  always_comb begin
    nrm_carry = s1_sum_q[MW+1];
    nrm_sig   = nrm_carry ? s1_sum_q[MW+1:1] : s1_sum_q[MW:0];
    nrm_exp   = {s1_exp_q[EW+1], s1_exp_q} + {{(EW+2){1'b0}}, nrm_carry};
    // Non-negative and at least the all-ones field value
    nrm_ovf   = !nrm_exp[EW+2] && (nrm_exp[EW+1:0] >= {2'b00, {EW{1'b1}}});
    // Negative or zero
    nrm_unf   = nrm_exp[EW+2] || (nrm_exp == '0);
  end

  // Pack selection: NaN beats everything, then overflow, underflow, normal
  logic [EW+MW:0] pk_d;
  logic           ovf_d;
  logic           unf_d;
  logic           inx_d;

  always_comb begin
    pk_d  = {s1_sign_q, nrm_exp[EW-1:0], nrm_sig[MW-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s1_inexact_q;
    if (s1_nan_q) begin
      pk_d  = {s1_sign_q, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      inx_d = 1'b0;
    end else if (nrm_ovf) begin
      pk_d  = {s1_sign_q, {EW{1'b1}}, {MW{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (nrm_unf) begin
      pk_d  = {s1_sign_q, {(EW+MW){1'b0}}};
      unf_d = 1'b1;
      inx_d = s1_nonzero_q;
    end
  end

  // Stage 2 register: holds the packed result stable while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q    <= 1'b0;
      s2_packed_q <= '0;
      s2_ovf_q    <= 1'b0;
      s2_unf_q    <= 1'b0;
      s2_inx_q    <= 1'b0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_packed_q <= pk_d;
        s2_ovf_q    <= ovf_d;
        s2_unf_q    <= unf_d;
        s2_inx_q    <= inx_d;
      end
    end
  end

  assign out_valid     = s2_vld_q;
  assign out_packed    = s2_packed_q;
  assign out_overflow  = s2_ovf_q;
  assign out_underflow = s2_unf_q;
  assign out_inexact   = s2_inx_q;

endmodule

// File: tb/tb_fpu_round_pack.sv
// Testbench for fpu_round_pack (default double-precision parameters).
// Directed IEEE vectors plus randomized streams checked against an arithmetic reference model.
// Covers latency, backpressure stability, in_ready under full pipeline, and mid-stream reset.
module tb_fpu_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [12:0] in_exponent;
  logic [55:0] in_significand;
  logic        in_is_nan;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_packed;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int total = 0;
  int bad   = 0;

  // Expected {packed, overflow, underflow, inexact} of beats accepted but not yet emitted
  logic [66:0] sb[$];

  bit          cur_s;
  longint      cur_e;
  logic [55:0] cur_sig;
  bit          cur_nan;

  always #5 clk = ~clk;

  fpu_round_pack #(
    .EXPONENT_WIDTH   (11),
    .SIGNIFICAND_WIDTH(52),
    .EXTRA_BITS       (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_significand(in_significand),
    .in_is_nan     (in_is_nan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_packed    (out_packed),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: round the 53-bit value by comparing the 3 extra bits to one half,
  // renormalise if the value reaches 2^53, then classify the exponent.
  function automatic logic [66:0] ref_model(input bit sgn, input longint e,
                                            input logic [55:0] sig, input bit nan);
    longint unsigned main_v;
    longint unsigned m;
    longint unsigned ext;
    longint          ee;
    bit              up;
    logic [63:0]     mm;
    logic [63:0]     eb;
    if (nan) return {sgn, 11'h7FF, 1'b1, 51'h0, 3'b000};
    main_v = longint'(sig >> 3);
    ext    = longint'(sig & 56'h7);
    up     = (ext > 4) || (ext == 4 && (main_v % 2 == 1));
    m      = main_v + (up ? 1 : 0);
    ee     = e;
    if (m >= (64'd1 << 53)) begin
      m  = m / 2;
      ee = ee + 1;
    end
    if (ee >= 2047) return {sgn, 11'h7FF, 52'h0, 3'b101};
    if (ee <= 0) return {sgn, 63'h0, 2'b01, (sig != 56'h0)};
    mm = m;
    eb = ee;
    return {sgn, eb[10:0], mm[51:0], 2'b00, (ext != 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input longint e, input logic [55:0] sig, input bit nan);
    logic [63:0] eb;
    eb             = e;
    in_sign        = s;
    in_exponent    = eb[12:0];
    in_significand = sig;
    in_is_nan      = nan;
    cur_s          = s;
    cur_e          = e;
    cur_sig        = sig;
    cur_nan        = nan;
  endtask

  task automatic rand_beat();
    logic [55:0] sig;
    longint      e;
    int          sel;
    sig     = {24'($urandom), 32'($urandom)};
    sig[55] = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 3) == 0) sig[54:3] = '1;
    sel = $urandom_range(0, 3);
    if (sel == 0)      e = longint'($urandom_range(0, 4)) - 2;
    else if (sel == 1) e = 2044 + longint'($urandom_range(0, 5));
    else               e = 1 + longint'($urandom_range(0, 2045));
    drive($urandom_range(0, 1), e, sig, ($urandom_range(0, 15) == 0));
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 56'h0, 0);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (out_packed !== 64'h0) begin bad++; $display("FAIL reset_out_packed: got %h want 0", out_packed); end
    total++;
    if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {out_overflow, out_underflow, out_inexact});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  typedef struct {
    bit          s;
    longint      e;
    logic [55:0] sig;
    bit          nan;
    logic [63:0] pk;
    logic [2:0]  fl;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{0, 1023, {1'b1, 52'h0, 3'b000}, 0, 64'h3FF0000000000000, 3'b000});
    v.push_back('{0, 1023, {1'b1, 52'h0, 3'b100}, 0, 64'h3FF0000000000000, 3'b001});
    v.push_back('{0, 1023, {1'b1, 52'h1, 3'b100}, 0, 64'h3FF0000000000002, 3'b001});
    v.push_back('{0, 1023, {1'b1, 52'h1, 3'b011}, 0, 64'h3FF0000000000001, 3'b001});
    v.push_back('{0, 1023, {1'b1, 52'h0, 3'b101}, 0, 64'h3FF0000000000001, 3'b001});
    v.push_back('{0, 1023, {1'b1, 52'hFFFFFFFFFFFFF, 3'b110}, 0, 64'h4000000000000000, 3'b001});
    v.push_back('{0, 2047, {1'b1, 52'h0, 3'b000}, 0, 64'h7FF0000000000000, 3'b101});
    v.push_back('{1, 0, {1'b1, 52'h0, 3'b000}, 0, 64'h8000000000000000, 3'b011});
    v.push_back('{0, 5, {1'b1, 52'h0, 3'b000}, 1, 64'h7FF8000000000000, 3'b000});
    v.push_back('{1, 2047, {1'b1, 52'h0, 3'b000}, 1, 64'hFFF8000000000000, 3'b000});
    v.push_back('{0, 2046, {1'b1, 52'hFFFFFFFFFFFFF, 3'b000}, 0, 64'h7FEFFFFFFFFFFFFF, 3'b000});
    v.push_back('{0, 2046, {1'b1, 52'hFFFFFFFFFFFFF, 3'b100}, 0, 64'h7FF0000000000000, 3'b101});
    v.push_back('{0, 1, {1'b1, 52'h0, 3'b000}, 0, 64'h0010000000000000, 3'b000});
    v.push_back('{0, 0, 56'h0, 0, 64'h0000000000000000, 3'b010});
    v.push_back('{1, -5, {1'b1, 52'h0, 3'b001}, 0, 64'h8000000000000000, 3'b011});
    out_ready = 1'b1;
    foreach (v[i]) begin
      drive(v[i].s, v[i].e, v[i].sig, v[i].nan);
      in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid); end
      tick();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_packed !== v[i].pk ||
          {out_overflow, out_underflow, out_inexact} !== v[i].fl) begin
        bad++;
        $display("FAIL dir%0d_result: got vld=%b %h fl=%b want vld=1 %h fl=%b", i, out_valid,
                 out_packed, {out_overflow, out_underflow, out_inexact}, v[i].pk, v[i].fl);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          pat[4] = '{1, 0, 0, 1};
    int          sent = 0;
    int          rcvd = 0;
    int          cyc = 0;
    bit          prev_stall = 0;
    bit          exp_rdy;
    logic [66:0] prev_o = '0;
    logic [66:0] want;
    sb.delete();
    while (rcvd < 6 && cyc < 200) begin
      if (sent < 6) begin
        drive(cyc[0], 1000 + longint'(sent), {1'b1, 20'($urandom), 32'($urandom), 3'($urandom)}, 0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = pat[cyc % 4][0];
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || {out_packed, out_overflow, out_underflow, out_inexact} !== prev_o) begin
          bad++;
          $display("FAIL bp_hold: got vld=%b %h want vld=1 %h", out_valid,
                   {out_packed, out_overflow, out_underflow, out_inexact}, prev_o);
        end
      end
      exp_rdy = !(sb.size() == 2 && !out_ready);
      total++;
      if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp_in_ready: got %b want %b", in_ready, exp_rdy); end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL bp_extra_output: got %h want none", out_packed);
        end else begin
          want = sb.pop_front();
          if ({out_packed, out_overflow, out_underflow, out_inexact} !== want) begin
            bad++;
            $display("FAIL bp_data: got %h want %h", {out_packed, out_overflow, out_underflow, out_inexact}, want);
          end
        end
        rcvd++;
      end
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back(ref_model(cur_s, cur_e, cur_sig, cur_nan));
        sent++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_o     = {out_packed, out_overflow, out_underflow, out_inexact};
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (rcvd != 6 || sb.size() != 0) begin
      bad++; $display("FAIL bp_count: got rcvd=%0d left=%0d want rcvd=6 left=0", rcvd, sb.size());
    end
  endtask

  task automatic test_random();
    int          n = 600;
    bit          exp_rdy;
    bit          prev_stall = 0;
    logic [66:0] prev_o = '0;
    logic [66:0] want;
    sb.delete();
    for (int cyc = 0; cyc < n + 10; cyc++) begin
      rand_beat();
      in_valid  = (cyc < n) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (cyc < n) ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || {out_packed, out_overflow, out_underflow, out_inexact} !== prev_o) begin
          bad++;
          $display("FAIL rnd_hold: got vld=%b %h want vld=1 %h", out_valid,
                   {out_packed, out_overflow, out_underflow, out_inexact}, prev_o);
        end
      end
      exp_rdy = !(sb.size() == 2 && !out_ready);
      total++;
      if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, exp_rdy); end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rnd_extra_output: got %h want none", out_packed);
        end else begin
          want = sb.pop_front();
          if ({out_packed, out_overflow, out_underflow, out_inexact} !== want) begin
            bad++;
            $display("FAIL rnd_data: got %h want %h", {out_packed, out_overflow, out_underflow, out_inexact}, want);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) sb.push_back(ref_model(cur_s, cur_e, cur_sig, cur_nan));
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_o     = {out_packed, out_overflow, out_underflow, out_inexact};
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL rnd_drain: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(0, 1023, {1'b1, 52'h12345, 3'b000}, 0);
    in_valid = 1'b1;
    tick();
    drive(1, 1030, {1'b1, 52'h6789A, 3'b000}, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_loaded: got vld=%b rdy=%b want vld=1 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_packed !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset: got vld=%b rdy=%b pk=%h want vld=0 rdy=1 pk=0", out_valid, in_ready, out_packed);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale%0d: got vld=%b want 0", i, out_valid); end
    end
    tick();
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_round_pack.md
Name: fpu_round_pack

Overview:
- Parametrised, pipelined successor to the combinational packer.
- Takes an unpacked result from the FPU datapath: sign, wide signed biased exponent, and significand with implied bit plus extra low-order bits.
- Rounds round-to-nearest-even, renormalises on rounding carry-out, saturates overflow to infinity, flushes underflow to signed zero, and packs to IEEE-754 layout.
- Sits between the arithmetic core and the result writeback. Uses valid/ready handshakes on both sides.

Parameters:
- EXPONENT_WIDTH, 11, packed exponent field width.
- SIGNIFICAND_WIDTH, 52, packed fraction width (implied bit excluded).
- EXTRA_BITS, 3, low-order bits below the fraction LSB (min 2). MSB is the round bit; OR of the rest is sticky.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts beat this cycle.
- in_sign  input  1  sign.
- in_exponent  input  EXPONENT_WIDTH+2  signed two's-complement biased exponent.
- in_significand  input  SIGNIFICAND_WIDTH+1+EXTRA_BITS  {implied bit, fraction, extra bits}.
- in_is_nan  input  1  result is NaN; overrides all other fields.
- out_valid  output  1  packed result valid.
- out_ready  input  1  downstream accepts.
- out_packed  output  1+EXPONENT_WIDTH+SIGNIFICAND_WIDTH  {sign, exponent, fraction}.
- out_overflow  output  1  overflow flag.
- out_underflow  output  1  underflow flag.
- out_inexact  output  1  inexact flag.

Behaviour:
- Reset: all stage valids clear. out_valid=0, out_packed=0, all flags 0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards every in-flight beat. No output is produced for those beats.
- Pipeline: 2 stages, latency 2 cycles from accepted input to out_valid under no backpressure. Throughput 1 beat/cycle.
- Stage 1 (round):
  - L = fraction LSB; R = MSB of extra bits; S = OR of remaining extra bits.
  - Round up iff R & (S | L).
  - Add 1 at the LSB to the (SIGNIFICAND_WIDTH+1)-bit significand, producing a (SIGNIFICAND_WIDTH+2)-bit sum.
  - inexact_pre = R | S.
- Stage 2 (normalise/pack):
  - If sum MSB is set (carry-out): shift right by 1 and exponent+1. The shifted-out bit is always 0, so no second rounding.
  - Let E = resulting exponent.
  - Overflow, E >= 2^EXPONENT_WIDTH-1: exponent all ones, fraction 0, sign kept. overflow=1, inexact=1.
  - Underflow, E <= 0 (flush-to-zero, no subnormals): exponent 0, fraction 0, sign kept. underflow=1. inexact=1 if the input significand was nonzero.
  - Otherwise: {sign, E[EXPONENT_WIDTH-1:0], fraction}. inexact=inexact_pre, overflow=0, underflow=0.
  - in_is_nan: sign kept, exponent all ones, fraction MSB=1 and rest 0 (canonical quiet NaN). All flags 0.
- Handshake:
  - A beat transfers on in_valid & in_ready (input side) and on out_valid & out_ready (output side).
  - Each stage advances when it is empty or the stage downstream of it advances.
  - in_ready = !stage1_valid | stage1_advances. It is combinational from out_ready; no skid buffer.
  - When out_valid=1 and out_ready=0, out_packed and flags hold stable and both stages stall.
  - A full pipeline with out_ready=1 accepts a new input in the same cycle it emits an output.
- Flags travel with their beat and are meaningful only while out_valid=1.

Test Plan:
- Exact pass-through: sign=0, exp=1023, sig={1,52'h0,3'b000}, out_ready=1. Expect out_packed=64'h3FF0000000000000 at cycle+2, all flags 0.
- Ties to even:
  - fraction=52'h0, extra=3'b100: expect 64'h3FF0000000000000, inexact=1.
  - fraction=52'h1, extra=3'b100: expect 64'h3FF0000000000002, inexact=1.
- Carry renormalise: exp=1023, sig={1,52'hFFFFFFFFFFFFF,3'b110}. Expect 64'h4000000000000000, inexact=1.
- Overflow/underflow/NaN:
  - exp=2047: expect 64'h7FF0000000000000, overflow=1, inexact=1.
  - sign=1, exp=0, nonzero sig: expect 64'h8000000000000000, underflow=1, inexact=1.
  - in_is_nan=1: expect 64'h7FF8000000000000, no flags.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1.
  - Expect in-order outputs, no loss or duplication.
  - Expect out_packed stable while stalled and in_ready=0 when both stages are full.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight.
  - Expect out_valid=0 next cycle, no stale outputs, in_ready=1.
